// File: rtl/debounce_pulse_multi.sv
// debounce_pulse_multi: per-channel two-flop synchroniser, consecutive-sample debouncer
// and registered one-cycle edge pulse (press, release or both).
module debounce_pulse_multi #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 5,
    parameter int EDGE_MODE       = 0
) (
    input  logic                C_CLOCK_50,
    input  logic                C_Reset,
    input  logic [CHANNELS-1:0] C_Count_In,
    output logic [CHANNELS-1:0] C_Level_Out,
    output logic [CHANNELS-1:0] C_Counter_Out
);
    // Any EDGE_MODE outside 0..2 falls back to press-only.
    localparam logic                 PRESS_EN = (EDGE_MODE != 1);
    localparam logic                 REL_EN   = (EDGE_MODE == 1) || (EDGE_MODE == 2);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {St_Idle, St_PressChk, St_Pressed, St_RelChk} state_t;

    logic [CHANNELS-1:0] sync1_q, sync2_q;

    always_ff @(posedge C_CLOCK_50 or posedge C_Reset) begin
        if (C_Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= C_Count_In;
            sync2_q <= sync1_q;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t               state_q;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic                 level_q, pulse_q;

        always_ff @(posedge C_CLOCK_50 or posedge C_Reset) begin
            if (C_Reset) begin
                state_q <= St_Idle;
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                case (state_q)
                    St_Idle: begin
                        if (sync2_q[c]) begin
                            state_q <= St_PressChk;
                            cnt_q   <= '0;
                        end
                    end
                    St_PressChk: begin
                        if (!sync2_q[c]) begin
                            state_q <= St_Idle;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= St_Pressed;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            pulse_q <= PRESS_EN;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    St_Pressed: begin
                        if (!sync2_q[c]) begin
                            state_q <= St_RelChk;
                            cnt_q   <= '0;
                        end
                    end
                    St_RelChk: begin
                        if (sync2_q[c]) begin
                            state_q <= St_Pressed;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= St_Idle;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                            pulse_q <= REL_EN;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                endcase
            end
        end

        assign C_Level_Out[c]   = level_q;
        assign C_Counter_Out[c] = pulse_q;
    end
endmodule

// File: tb/tb_debounce_pulse_multi.sv
// tb_debounce_pulse_multi: three instances (press, release, both-edge) driven together,
// checked each cycle against a run-length reference model through a scoreboard queue.
module tb_debounce_pulse_multi;
    localparam int CH = 4;
    localparam int D  = 4;

    typedef struct packed {
        logic [2:0][CH-1:0] l;
        logic [2:0][CH-1:0] p;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] din = '0;
    logic [CH-1:0] lvl [3];
    logic [CH-1:0] pls [3];

    int   n_chk = 0, n_fail = 0, cyc = 0, last_k = 0;
    int   pc [3][CH];
    int   fpc [3][CH];
    exp_t q [$];

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        debounce_pulse_multi #(
            .CHANNELS(CH), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(3), .EDGE_MODE(m)
        ) dut (
            .C_CLOCK_50(clk),
            .C_Reset(rst),
            .C_Count_In(din),
            .C_Level_Out(lvl[m]),
            .C_Counter_Out(pls[m])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr();
        for (int m = 0; m < 3; m++)
            for (int c = 0; c < CH; c++) begin
                pc[m][c]  = 0;
                fpc[m][c] = -1;
            end
    endtask

    task automatic hold(input logic [CH-1:0] v, input int n);
        @(negedge clk);
        din    = v;
        last_k = cyc + 1;
        repeat (n) @(posedge clk);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference: the FSM sees the raw sample from two edges earlier; a level flips once
    // D+1 consecutive seen samples disagree with it, any agreeing sample restarts the run.
    initial begin
        logic [CH-1:0] hist [$];
        logic [CH-1:0] L, s2;
        int            run [CH];
        exp_t          e;
        L = '0;
        for (int c = 0; c < CH; c++) run[c] = 0;
        forever begin
            @(posedge clk);
            e = '0;
            if (rst) begin
                hist.delete();
                L = '0;
                for (int c = 0; c < CH; c++) run[c] = 0;
            end else begin
                hist.push_back(din);
                s2 = (hist.size() >= 3) ? hist[hist.size()-3] : '0;
                if (hist.size() > 3) void'(hist.pop_front());
                for (int c = 0; c < CH; c++) begin
                    if (s2[c] != L[c]) begin
                        run[c]++;
                        if (run[c] == D + 1) begin
                            L[c]   = ~L[c];
                            run[c] = 0;
                            e.p[0][c] = L[c];
                            e.p[1][c] = ~L[c];
                            e.p[2][c] = 1'b1;
                        end
                    end else begin
                        run[c] = 0;
                    end
                end
                for (int m = 0; m < 3; m++) e.l[m] = L;
            end
            q.push_back(e);
        end
    end

    initial begin
        exp_t          e;
        logic [CH-1:0] prevp [3];
        for (int m = 0; m < 3; m++) prevp[m] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                chk("scoreboard_empty", 0, 1);
            end else begin
                e = q.pop_front();
                for (int m = 0; m < 3; m++) begin
                    chk($sformatf("level_mode%0d", m), int'(lvl[m]), int'(e.l[m]));
                    chk($sformatf("pulse_mode%0d", m), int'(pls[m]), int'(e.p[m]));
                    chk($sformatf("back_to_back_mode%0d", m), int'(pls[m] & prevp[m]), 0);
                    prevp[m] = pls[m];
                    for (int c = 0; c < CH; c++)
                        if (pls[m][c]) begin
                            pc[m][c]++;
                            if (fpc[m][c] < 0) fpc[m][c] = cyc;
                        end
                end
            end
        end
    end

    initial begin
        clr();
        repeat (3) @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) begin
            chk("reset_level", int'(lvl[m]), 0);
            chk("reset_pulse", int'(pls[m]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        hold('0, 4);

        clr();
        hold(4'b0001, 20);
        chk("press_count_ch0", pc[0][0], 1);
        chk("press_latency_ch0", fpc[0][0] - last_k, D + 2);
        chk("press_other_channels", pc[0][1] + pc[0][2] + pc[0][3], 0);
        chk("release_mode_no_press_pulse", pc[1][0], 0);
        hold(4'b0000, 20);
        chk("release_mode_one_pulse", pc[1][0], 1);
        chk("both_mode_two_pulses", pc[2][0], 2);

        clr();
        repeat (2) begin
            hold(4'b0010, 2);
            hold(4'b0000, 2);
        end
        hold(4'b0000, 10);
        chk("bounce_no_pulse", pc[0][1] + pc[1][1] + pc[2][1], 0);
        chk("bounce_level_low", int'(lvl[0][1]), 0);
        hold(4'b0010, 20);
        chk("held_one_pulse", pc[0][1], 1);
        hold(4'b0000, 20);

        clr();
        hold(4'b0100, 20);
        chk("rel_mode_press_silent", pc[1][2], 0);
        hold(4'b0000, 20);
        chk("rel_mode_release_pulse", pc[1][2], 1);
        chk("rel_mode_latency", fpc[1][2] - last_k, D + 2);

        clr();
        hold(4'b1000, 10);
        hold(4'b0000, 1);
        hold(4'b1000, 10);
        hold(4'b0000, 20);
        chk("both_mode_glitch_ignored", pc[2][3], 2);

        clr();
        hold(4'b0011, 20);
        chk("simul_ch0_latency", fpc[0][0] - last_k, D + 2);
        chk("simul_same_cycle", fpc[0][1], fpc[0][0]);
        hold(4'b0100, 4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int m = 0; m < 3; m++) begin
            chk("reset_async_level", int'(lvl[m]), 0);
            chk("reset_async_pulse", int'(pls[m]), 0);
        end
        repeat (3) @(posedge clk);
        clr();
        @(negedge clk);
        rst    = 1'b0;
        last_k = cyc + 1;
        repeat (20) @(posedge clk);
        chk("post_reset_press_count", pc[0][2], 1);
        chk("post_reset_press_latency", fpc[0][2] - last_k, D + 2);
        chk("post_reset_other_channels", pc[0][0] + pc[0][1] + pc[0][3], 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                rst = 1'b1;
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
            end
            hold(CH'($urandom), $urandom_range(1, 12));
        end
        hold('0, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
